// File: rtl/i2c_slave_pkg.sv
// Shared types and bus constants for the I2C slave responder.
package i2c_slave_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } i2c_slv_state_e;

    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;
    localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Pad synchronizers, one-cycle history and START/STOP/SCL edge detection.
module i2c_line_sync (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic scl_pad_i,
    input  logic sda_pad_i,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_d;
    logic       sda_d;

    // Idle bus level is high, so reset the chain to 1 to avoid phantom edges.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_pad_i};
            sda_sync <= {sda_sync[0], sda_pad_i};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave with an auto-incrementing register bank and local write strobe.
module i2c_slave_ctrl
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0]  SLV_ADDR  = 7'h50,
    parameter int unsigned REG_COUNT = 8,
    parameter int unsigned IDX_W     = $clog2(REG_COUNT)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             scl_pad_i,
    input  logic             sda_pad_i,
    output logic             scl_pad_o,
    output logic             scl_padoen_o,
    output logic             sda_pad_o,
    output logic             sda_padoen_o,
    output logic             busy_o,
    output logic             wr_stb_o,
    output logic [IDX_W-1:0] wr_idx_o,
    output logic [7:0]       wr_dat_o
);

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync u_line_sync (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .scl_pad_i (scl_pad_i),
        .sda_pad_i (sda_pad_i),
        .scl_s     (scl_s),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_slv_state_e state, next_state;

    logic [7:0]       shreg;
    logic [2:0]       bit_cnt;
    logic             phase;
    logic             first;
    logic [IDX_W-1:0] ptr;
    logic [7:0]       regs [REG_COUNT];
    logic             sda_drive;
    logic [7:0]       rx_byte;

    assign rx_byte      = {shreg[6:0], sda_s};
    assign scl_pad_o    = 1'b0;
    assign scl_padoen_o = 1'b1;
    assign sda_pad_o    = 1'b0;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= next_state;
    end

    // phase: in ACK states, set once SDA is pulled; in RD_ACK, set once the master ACKed.
    always_comb begin
        next_state = state;
        if (stop_det) begin
            next_state = IDLE;
        end else if (start_det) begin
            next_state = ADDR;
        end else begin
            case (state)
                ADDR:     if (scl_rise && bit_cnt == 3'd7)
                              next_state = (rx_byte[7:1] == SLV_ADDR) ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (scl_fall && phase)
                              next_state = (shreg[0] == I2C_RW_READ) ? RD_DATA : WR_DATA;
                WR_DATA:  if (scl_rise && bit_cnt == 3'd7) next_state = WR_ACK;
                WR_ACK:   if (scl_fall && phase) next_state = WR_DATA;
                RD_DATA:  if (scl_fall && bit_cnt == 3'd7) next_state = RD_ACK;
                // Re-entry to RD_DATA waits for SCL low so the next bit 7 never moves SDA under high SCL.
                RD_ACK: begin
                    if (scl_rise && scl_s && sda_s == I2C_NACK) next_state = IGNORE;
                    else if (scl_fall && phase)                 next_state = RD_DATA;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sda_drive = 1'b0;
        busy_o    = 1'b0;
        case (state)
            ADDR_ACK, WR_ACK: begin
                sda_drive = phase;
                busy_o    = 1'b1;
            end
            RD_DATA: begin
                sda_drive = ~shreg[7];
                busy_o    = 1'b1;
            end
            WR_DATA, RD_ACK: busy_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            shreg        <= '0;
            bit_cnt      <= '0;
            phase        <= 1'b0;
            first        <= 1'b0;
            ptr          <= '0;
            wr_stb_o     <= 1'b0;
            wr_idx_o     <= '0;
            wr_dat_o     <= '0;
            sda_padoen_o <= 1'b1;
            for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            wr_stb_o     <= 1'b0;
            sda_padoen_o <= ~sda_drive;
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (first) begin
                                ptr   <= rx_byte[IDX_W-1:0];
                                first <= 1'b0;
                            end else begin
                                regs[ptr] <= rx_byte;
                                wr_stb_o  <= 1'b1;
                                wr_idx_o  <= ptr;
                                wr_dat_o  <= rx_byte;
                                ptr       <= ptr + IDX_W'(1);
                            end
                        end
                    end
                end
                ADDR_ACK, WR_ACK: if (scl_fall) phase <= 1'b1;
                RD_DATA: begin
                    if (scl_fall) begin
                        shreg   <= {shreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                RD_ACK: begin
                    if (scl_rise && scl_s) begin
                        ptr   <= ptr + IDX_W'(1);
                        phase <= (sda_s == I2C_ACK);
                    end
                end
                default: ;
            endcase
            if (state == ADDR_ACK && next_state == WR_DATA) first <= 1'b1;
            if (state != RD_DATA && next_state == RD_DATA) shreg <= regs[ptr];
            if (start_det || stop_det || next_state != state) begin
                bit_cnt <= '0;
                phase   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bus-level bench: bit-banged I2C master against a transaction-level register model.
module tb_i2c_slave_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_line;
    logic       scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
    logic       busy_o, wr_stb_o;
    logic [2:0] wr_idx_o;
    logic [7:0] wr_dat_o;

    int n_assert = 0;
    int n_fail   = 0;

    int mregs [8];
    int mptr = 0;
    int ex_idx[$], ex_dat[$], cap_idx[$], cap_dat[$];
    logic [7:0] wbuf [8];
    bit mon_en = 1'b0, mon_oen_low = 1'b0, mon_busy = 1'b0;

    assign sda_line = m_sda & sda_padoen_o;

    always #5 clk = ~clk;

    i2c_slave_ctrl #(.SLV_ADDR(7'h50), .REG_COUNT(8)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .scl_pad_i    (m_scl),
        .sda_pad_i    (sda_line),
        .scl_pad_o    (scl_pad_o),
        .scl_padoen_o (scl_padoen_o),
        .sda_pad_o    (sda_pad_o),
        .sda_padoen_o (sda_padoen_o),
        .busy_o       (busy_o),
        .wr_stb_o     (wr_stb_o),
        .wr_idx_o     (wr_idx_o),
        .wr_dat_o     (wr_dat_o)
    );

    always @(negedge clk) begin
        if (wr_stb_o) begin
            cap_idx.push_back(int'(wr_idx_o));
            cap_dat.push_back(int'(wr_dat_o));
        end
        if (mon_en) begin
            if (!sda_padoen_o) mon_oen_low = 1'b1;
            if (busy_o)        mon_busy    = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        cyc(6); m_sda = 1'b1; cyc(4); m_scl = 1'b1; cyc(8); m_sda = 1'b0; cyc(8); m_scl = 1'b0;
    endtask

    task automatic i2c_stop();
        cyc(6); m_sda = 1'b0; cyc(4); m_scl = 1'b1; cyc(8); m_sda = 1'b1; cyc(8);
    endtask

    task automatic send_bit(input bit b, output bit s);
        cyc(6); m_sda = b; cyc(4); m_scl = 1'b1; cyc(4); s = sda_line; cyc(4); m_scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output bit ack);
        bit s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, ack);
    endtask

    task automatic read_byte(input bit ackb, output logic [7:0] d);
        bit s;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, s);
            d = {d[6:0], s};
        end
        send_bit(ackb, s);
    endtask

    // Start + address + n bytes from wbuf; model: first byte sets pointer, the rest are register writes.
    task automatic xfer_write(input logic [7:0] addr, input int n);
        bit ack;
        bit match;
        match = (addr[7:1] == 7'h50) && !addr[0];
        i2c_start();
        write_byte(addr, ack);
        chk("addr_ack", 32'(ack), match ? 32'd0 : 32'd1);
        for (int k = 0; k < n; k++) begin
            write_byte(wbuf[k], ack);
            chk("data_ack", 32'(ack), match ? 32'd0 : 32'd1);
            if (match) begin
                if (k == 0) mptr = int'(wbuf[k]) % 8;
                else begin
                    mregs[mptr] = int'(wbuf[k]);
                    ex_idx.push_back(mptr);
                    ex_dat.push_back(int'(wbuf[k]));
                    mptr = (mptr + 1) % 8;
                end
            end
        end
    endtask

    task automatic xfer_read(input int n);
        bit ack;
        logic [7:0] d;
        i2c_start();
        write_byte(8'hA1, ack);
        chk("rd_addr_ack", 32'(ack), 32'd0);
        for (int k = 0; k < n; k++) begin
            read_byte(k == n - 1, d);
            chk("rd_data", 32'(d), 32'(mregs[mptr]));
            mptr = (mptr + 1) % 8;
        end
    endtask

    task automatic chk_strobes();
        chk("stb_count", 32'(cap_idx.size()), 32'(ex_idx.size()));
        for (int k = 0; k < ex_idx.size() && k < cap_idx.size(); k++) begin
            chk("stb_idx", 32'(cap_idx[k]), 32'(ex_idx[k]));
            chk("stb_dat", 32'(cap_dat[k]), 32'(ex_dat[k]));
        end
        cap_idx.delete(); cap_dat.delete(); ex_idx.delete(); ex_dat.delete();
    endtask

    initial begin
        bit s;
        int n;
        foreach (mregs[i]) mregs[i] = 0;
        cyc(4);
        chk("rst_oen",    32'(sda_padoen_o), 32'd1);
        chk("rst_busy",   32'(busy_o),       32'd0);
        chk("rst_stb",    32'(wr_stb_o),     32'd0);
        chk("rst_idx",    32'(wr_idx_o),     32'd0);
        chk("rst_dat",    32'(wr_dat_o),     32'd0);
        chk("scl_pad_o",  32'(scl_pad_o),    32'd0);
        chk("scl_oen",    32'(scl_padoen_o), 32'd1);
        chk("sda_pad_o",  32'(sda_pad_o),    32'd0);
        rst = 1'b0;
        cyc(10);

        // Write then read back
        wbuf[0] = 8'h02; wbuf[1] = 8'h11; wbuf[2] = 8'h22;
        xfer_write(8'hA0, 3);
        cyc(2);
        chk("busy_in_xfer", 32'(busy_o), 32'd1);
        i2c_stop();
        chk("busy_after_stop", 32'(busy_o), 32'd0);
        chk("stb_n_wr1", 32'(cap_idx.size()), 32'd2);
        chk_strobes();
        wbuf[0] = 8'h02;
        xfer_write(8'hA0, 1);
        xfer_read(2);
        i2c_stop();
        chk("reg2_const", 32'(mregs[2]), 32'h11);

        // Address mismatch
        mon_oen_low = 1'b0; mon_busy = 1'b0; mon_en = 1'b1;
        wbuf[0] = 8'h01; wbuf[1] = 8'h55;
        xfer_write(8'hA4, 2);
        i2c_stop();
        mon_en = 1'b0;
        chk("mismatch_oen", 32'(mon_oen_low), 32'd0);
        chk("mismatch_busy", 32'(mon_busy), 32'd0);
        chk_strobes();

        // Pointer wrap
        wbuf[0] = 8'h07; wbuf[1] = 8'h33; wbuf[2] = 8'h44;
        xfer_write(8'hA0, 3);
        i2c_stop();
        chk_strobes();
        wbuf[0] = 8'h07;
        xfer_write(8'hA0, 1);
        xfer_read(2);
        i2c_stop();

        // STOP mid-byte keeps the pointer
        wbuf[0] = 8'h03;
        xfer_write(8'hA0, 1);
        send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s); send_bit(1'b1, s);
        i2c_stop();
        chk("midstop_oen", 32'(sda_padoen_o), 32'd1);
        chk("midstop_busy", 32'(busy_o), 32'd0);
        chk_strobes();
        xfer_read(1);
        i2c_stop();

        // Reset while the slave drives a 0 data bit (reg 2 = 0x11, MSB 0)
        wbuf[0] = 8'h02;
        xfer_write(8'hA0, 1);
        i2c_start();
        write_byte(8'hA1, s);
        chk("rr_addr_ack", 32'(s), 32'd0);
        cyc(6);
        chk("rr_driving", 32'(sda_padoen_o), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rr_released", 32'(sda_padoen_o), 32'd1);
        cyc(1);
        rst = 1'b0;
        foreach (mregs[i]) mregs[i] = 0;
        mptr = 0;
        i2c_stop();
        xfer_read(1);
        i2c_stop();
        chk_strobes();

        // Randomized writes (some to a foreign address) and reads
        for (int it = 0; it < 8; it++) begin
            n = int'($urandom_range(1, 4));
            for (int k = 0; k < 8; k++) wbuf[k] = 8'($urandom_range(0, 255));
            xfer_write(($urandom_range(0, 3) == 0) ? 8'hA6 : 8'hA0, n + 1);
            i2c_stop();
            chk_strobes();
            wbuf[0] = 8'($urandom_range(0, 255));
            xfer_write(8'hA0, 1);
            xfer_read(int'($urandom_range(1, 4)));
            i2c_stop();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
